// File: rtl/tachometer_pkg.sv
// Shared types and defaults for the tachometer pulse counter.
package tachometer_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_COUNT   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_HOLDOFF = 3'd4
    } tach_state_e;

endpackage

// File: rtl/tachometer_pulse_counter_if.sv
// Gate-timer handshake bundle between the tachometer and its window timer.
interface tachometer_pulse_counter_if;
    // The counter raises tachometer_ready to request a window. The timer answers
    // with timer_reset=0 / timer_on=1 while the window runs, drops timer_on for
    // one cycle to close it, and may raise timer_reset at any time to abort.
    logic timer_on;
    logic timer_reset;
    logic tachometer_ready;

    modport master (output timer_on, output timer_reset, input tachometer_ready);
    modport slave  (input timer_on, input timer_reset, output tachometer_ready);
endinterface

// File: rtl/tach_input_filter.sv
// Two-flop synchronizer, run-length glitch filter and rising-edge detect for tach_in.
module tach_input_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clock,
    input  logic system_reset,
    input  logic tach_in,
    output logic level,
    output logic rise
);

    logic       sync_0;
    logic       sync_1;
    logic [7:0] run_cnt;

    // rise is registered alongside level, so it is high exactly in the first cycle level reads 1.
    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            sync_0  <= 1'b0;
            sync_1  <= 1'b0;
            level   <= 1'b0;
            rise    <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync_0 <= tach_in;
            sync_1 <= sync_0;
            rise   <= 1'b0;
            if (sync_1 != level) begin
                if (run_cnt == 8'(FILTER_CYCLES - 1)) begin
                    level   <= sync_1;
                    rise    <= sync_1;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tachometer_pulse_counter.sv
// Counts filtered tach rising edges over gate-timer windows and latches the result.
module tachometer_pulse_counter
    import tachometer_pkg::*;
#(
    parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
    parameter int FILTER_CYCLES  = 4,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   system_reset,
    input  logic                   tach_in,
    input  logic                   timer_on,
    input  logic                   timer_reset,
    output logic                   tachometer_ready,
    output logic [COUNT_WIDTH-1:0] pulse_count,
    output logic                   count_valid,
    output logic                   overflow,
    output tach_state_e            state
);

    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    tach_state_e              next_state;
    logic                     rise;
    logic                     level;
    logic [COUNT_WIDTH-1:0]   win_count;
    logic                     win_ovf;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     reset_seen;
    logic                     hold_done;
    logic                     win_clear;
    logic                     win_inc;
    logic                     load;

    tach_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clock        (clock),
        .system_reset (system_reset),
        .tach_in      (tach_in),
        .level        (level),
        .rise         (rise)
    );

    assign hold_done   = (hold_cnt >= HOLD_W'(HOLDOFF_CYCLES - 1));
    assign count_valid = (state == ST_LATCH);

    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        tachometer_ready = 1'b0;
        win_clear        = 1'b0;
        win_inc          = 1'b0;
        load             = 1'b0;
        case (state)
            ST_IDLE: begin
                next_state = ST_ARM;
            end
            ST_ARM: begin
                tachometer_ready = 1'b1;
                win_clear        = 1'b1;
                if (!timer_reset && timer_on) begin
                    next_state = ST_COUNT;
                end
            end
            ST_COUNT: begin
                tachometer_ready = 1'b1;
                // An abort discards the window; a closing cycle latches it without its own edge.
                if (timer_reset) begin
                    next_state = ST_HOLDOFF;
                end else if (!timer_on) begin
                    next_state = ST_LATCH;
                    load       = 1'b1;
                end else begin
                    win_inc = rise;
                end
            end
            ST_LATCH: begin
                next_state = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hold_done && (reset_seen || timer_reset)) begin
                    next_state = ST_ARM;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            win_count <= '0;
            win_ovf   <= 1'b0;
        end else if (win_clear) begin
            win_count <= '0;
            win_ovf   <= 1'b0;
        end else if (win_inc) begin
            if (&win_count) begin
                win_ovf <= 1'b1;
            end else begin
                win_count <= win_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            pulse_count <= '0;
            overflow    <= 1'b0;
        end else if (load) begin
            pulse_count <= win_count;
            overflow    <= win_ovf;
        end
    end

    // Holdoff needs both the minimum dwell and proof the timer went back into reset.
    always_ff @(posedge clock or negedge system_reset) begin
        if (!system_reset) begin
            hold_cnt   <= '0;
            reset_seen <= 1'b0;
        end else if (state != ST_HOLDOFF) begin
            hold_cnt   <= '0;
            reset_seen <= 1'b0;
        end else begin
            if (!hold_done) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (timer_reset) begin
                reset_seen <= 1'b1;
            end
        end
    end

endmodule
